// File: rtl/enc_dec_link_n.sv
// rtl/enc_dec_link_n.sv - two-stage encode->decode link with valid/ready flow and error counting
// Stage 1 encodes the request vector to an index; stage 2 decodes it back to a one-hot grant.
module enc_dec_link_n #(
  parameter int N      = 4,
  parameter int W      = $clog2(N),
  parameter bit STRICT = 1'b0,
  parameter int CW     = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_req,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_grant,
  output logic [W-1:0]  out_idx,
  output logic          out_err,
  input  logic          clr_cnt,
  output logic [CW-1:0] err_cnt
);

  localparam logic [CW-1:0] CNT_MAX = '1;

  logic         s1_valid;
  logic [W-1:0] s1_idx;
  logic         s1_zero;
  logic         s1_multi;

  logic         s1_adv;
  logic         s2_adv;
  logic         in_xfer;
  logic         out_xfer;
  logic         s1_move;

  logic [W-1:0] enc_idx;
  logic         enc_zero;
  logic         enc_multi;

  logic         dec_err;
  logic [N-1:0] dec_grant;
  logic [W-1:0] dec_idx;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;
  assign s1_move  = s1_valid && s2_adv;

  // Scan from the top down so the last hit is the lowest set bit.
  always_comb begin
    enc_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (in_req[i]) enc_idx = W'(i);
    end
  end

  assign enc_zero  = (in_req == '0);
  assign enc_multi = |(in_req & (in_req - N'(1)));

  assign dec_err   = s1_zero || (STRICT && s1_multi);
  assign dec_grant = dec_err ? '0 : (N'(1) << s1_idx);
  assign dec_idx   = dec_err ? '0 : s1_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_idx   <= '0;
      s1_zero  <= 1'b0;
      s1_multi <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_xfer) begin
        s1_idx   <= enc_idx;
        s1_zero  <= enc_zero;
        s1_multi <= enc_multi;
      end
    end
  end

  // Output registers only change on an advance, so a stalled beat stays stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_grant <= '0;
      out_idx   <= '0;
      out_err   <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_move) begin
        out_grant <= dec_grant;
        out_idx   <= dec_idx;
        out_err   <= dec_err;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (clr_cnt) begin
      err_cnt <= '0;
    end else if (out_xfer && out_err && (err_cnt != CNT_MAX)) begin
      err_cnt <= err_cnt + CW'(1);
    end
  end

endmodule
